dbus_axi_arbiter: RTL

- Shares the core's single AXI DBus port between two requesters: requester 0 is the core DBus, requester 1 is a secondary master (DMA or debug).
- Round-robin grant, locked for the duration of a transfer.
- Timeout watchdog converts a hung slave into an access fault.
- Sits between the core/secondary master and the AXI bridge.
- Uses the same rd_en/wr_en/addr/wr_data/wr_strobe/rd_data/busy/access_fault handshake as the core's AXI port.

---
 rtl/dbus_axi_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/dbus_axi_arbiter.sv
// dbus_axi_arbiter: shares one AXI DBus port between two requesters.
//   Requester 0 is the core DBus, requester 1 a secondary master (DMA/debug).
//   Round-robin on ties; the grant is locked while the slave stalls, and a
//   watchdog turns a slave stuck busy for TIMEOUT_CYCLES into an access fault.
//   Address/data are muxed combinationally, so the arbiter adds no latency.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   mN_rd_en/wr_en/addr/wr_data/wr_strobe   requester N request (N=0,1)
//   mN_rd_data/busy/access_fault        response to requester N
//   axi_rd_en/wr_en/addr/wr_data/wr_strobe  downstream request
//   axi_rd_data/busy/access_fault       downstream response
// Optional: define DBUS_ARB_STATS_EN to add saturating statistics outputs
//   grant_cnt0, grant_cnt1, stall_cnt (16 bit) and timeout_cnt (8 bit).
module dbus_axi_arbiter #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      m0_rd_en,
    input  logic                      m0_wr_en,
    input  logic [AXI_ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]               m0_wr_data,
    input  logic [3:0]                m0_wr_strobe,
    output logic [31:0]               m0_rd_data,
    output logic                      m0_busy,
    output logic                      m0_access_fault,
    input  logic                      m1_rd_en,
    input  logic                      m1_wr_en,
    input  logic [AXI_ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]               m1_wr_data,
    input  logic [3:0]                m1_wr_strobe,
    output logic [31:0]               m1_rd_data,
    output logic                      m1_busy,
    output logic                      m1_access_fault,
    output logic                      axi_rd_en,
    output logic                      axi_wr_en,
    output logic [AXI_ADDR_WIDTH-1:0] axi_addr,
    output logic [31:0]               axi_wr_data,
    output logic [3:0]                axi_wr_strobe,
    input  logic [31:0]               axi_rd_data,
    input  logic                      axi_busy,
    input  logic                      axi_access_fault
`ifdef DBUS_ARB_STATS_EN
    ,
    output logic [15:0]               grant_cnt0,
    output logic [15:0]               grant_cnt1,
    output logic [15:0]               stall_cnt,
    output logic [7:0]                timeout_cnt
`endif
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;

    logic req0, req1;
    logic gnt_valid, gnt_id;
    logic timeout;
    logic sel_rd, sel_wr;

    assign req0 = m0_rd_en | m0_wr_en;
    assign req1 = m1_rd_en | m1_wr_en;

    // Grant selection: round-robin in IDLE, only the owner while locked.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    gnt_valid = 1'b1;
                    gnt_id    = ~last_grant;
                end else if (req0 || req1) begin
                    gnt_valid = 1'b1;
                    gnt_id    = req1;
                end
            end
            LOCK0: gnt_valid = req0;
            LOCK1: begin
                gnt_valid = req1;
                gnt_id    = 1'b1;
            end
            default: ;
        endcase
    end

    assign timeout = (TIMEOUT_CYCLES != 0) && (state != IDLE) && gnt_valid
                     && axi_busy && (cnt == CNT_TO);

    assign sel_rd = gnt_id ? m1_rd_en : m0_rd_en;
    assign sel_wr = gnt_id ? m1_wr_en : m0_wr_en;

    // Downstream mux; everything reads 0 in reset or without a grant.
    always_comb begin
        axi_rd_en     = 1'b0;
        axi_wr_en     = 1'b0;
        axi_addr      = '0;
        axi_wr_data   = '0;
        axi_wr_strobe = '0;
        if (rst_n && gnt_valid) begin
            axi_rd_en     = sel_rd & ~timeout;
            axi_wr_en     = sel_wr & ~timeout;
            axi_addr      = gnt_id ? m1_addr      : m0_addr;
            axi_wr_data   = gnt_id ? m1_wr_data   : m0_wr_data;
            axi_wr_strobe = gnt_id ? m1_wr_strobe : m0_wr_strobe;
        end
    end

    // Responses: granted side sees the slave (or the forced fault), a waiting
    // requester is stalled, an idle requester sees zeros.
    always_comb begin
        m0_rd_data      = '0;
        m0_busy         = 1'b0;
        m0_access_fault = 1'b0;
        m1_rd_data      = '0;
        m1_busy         = 1'b0;
        m1_access_fault = 1'b0;
        if (rst_n) begin
            if (gnt_valid && !gnt_id) begin
                m0_busy         = timeout ? 1'b0 : axi_busy;
                m0_access_fault = timeout ? 1'b1 : axi_access_fault;
                m0_rd_data      = timeout ? 32'd0 : axi_rd_data;
            end else if (req0) begin
                m0_busy = 1'b1;
            end
            if (gnt_valid && gnt_id) begin
                m1_busy         = timeout ? 1'b0 : axi_busy;
                m1_access_fault = timeout ? 1'b1 : axi_access_fault;
                m1_rd_data      = timeout ? 32'd0 : axi_rd_data;
            end else if (req1) begin
                m1_busy = 1'b1;
            end
        end
    end

    // Lock FSM with saturating watchdog counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        if (axi_busy) begin
                            state <= gnt_id ? LOCK1 : LOCK0;
                            cnt   <= CNT_W'(1);
                        end else begin
                            last_grant <= gnt_id;
                        end
                    end
                end
                LOCK0, LOCK1: begin
                    if (!gnt_valid) begin
                        // owner withdrew its request: abort without fault
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (!axi_busy || timeout) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        last_grant <= gnt_id;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef DBUS_ARB_STATS_EN
    logic done_c, stall_c;

    // Completions exclude aborts (no grant) and timeouts (slave still busy).
    assign done_c  = gnt_valid && !axi_busy;
    assign stall_c = gnt_valid && (gnt_id ? req0 : req1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt0  <= '0;
            grant_cnt1  <= '0;
            stall_cnt   <= '0;
            timeout_cnt <= '0;
        end else begin
            if (done_c && !gnt_id && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (done_c &&  gnt_id && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
            if (stall_c && stall_cnt != 16'hFFFF)            stall_cnt  <= stall_cnt + 16'd1;
            if (timeout && timeout_cnt != 8'hFF)             timeout_cnt <= timeout_cnt + 8'd1;
        end
    end
`endif

endmodule
